// File: rtl/fp_wb_arbiter_if.sv
// Bus bundle between the FP producers, the writeback arbiter and the
// register file write ports. Producers and the register file sit on the
// master side; the arbiter is the slave.
interface fp_wb_arbiter_if #(
  parameter int FPRegWidth = 32,
  parameter int NREQ       = 4
);
  // producer side
  logic                       hold;
  logic [NREQ-1:0]            req;
  logic [4*NREQ-1:0]          req_wn;
  logic [FPRegWidth*NREQ-1:0] req_d;
  logic [NREQ-1:0]            ack;

  // register file write ports
  logic                       we1;
  logic                       we2;
  logic [3:0]                 wn1;
  logic [3:0]                 wn2;
  logic [FPRegWidth-1:0]      d1;
  logic [FPRegWidth-1:0]      d2;

  modport slave (
    input  hold, req, req_wn, req_d,
    output ack, we1, we2, wn1, wn2, d1, d2
  );

  modport master (
    output hold, req, req_wn, req_d,
    input  ack, we1, we2, wn1, wn2, d1, d2
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// Writeback arbiter for the FP register file. Up to two of four producers
// are granted per cycle in round-robin order; the second grant never targets
// the same register as the first, so both register file ports can be written
// without losing a result. Port 1 is always filled before port 2.
module fp_wb_arbiter #(
  parameter int FPRegWidth = 32,
  parameter int NREQ       = 4   // pointer logic is 2 bits wide, so this stays 4
) (
  input  logic           clk,
  input  logic           Clr,
  fp_wb_arbiter_if.slave bus
);

  // round-robin pointer: first index examined by the scan
  logic [1:0]            ptr_reg;
  logic [1:0]            ptr_next;

  // registered write ports
  logic                  we1_reg;
  logic                  we2_reg;
  logic [3:0]            wn1_reg;
  logic [3:0]            wn2_reg;
  logic [FPRegWidth-1:0] d1_reg;
  logic [FPRegWidth-1:0] d2_reg;

  // unpacked views of the request bundle and the rotated scan order
  logic [3:0]            wn_arr   [NREQ];
  logic [FPRegWidth-1:0] d_arr    [NREQ];
  logic [1:0]            scan_idx [NREQ];
  logic [NREQ-1:0]       ack_vec;

  // winners of the scan
  logic                  g1_vld;
  logic [1:0]            g1_idx;
  logic                  g2_vld;
  logic [1:0]            g2_idx;
  logic                  grant_en;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign wn_arr[gi]   = bus.req_wn[4*gi +: 4];
      assign d_arr[gi]    = bus.req_d[FPRegWidth*gi +: FPRegWidth];
      // 2-bit add wraps naturally, giving ptr, ptr+1, ptr+2, ptr+3 mod 4
      assign scan_idx[gi] = ptr_reg + 2'(gi);
    end
  endgenerate

  // Priority scan: first requester from ptr wins port 1, next requester
  // with a different destination wins port 2; same-destination ones wait.
  always_comb begin
    g1_vld = 1'b0;
    g1_idx = 2'd0;
    g2_vld = 1'b0;
    g2_idx = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req[scan_idx[k]]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx[k];
        end else if (!g2_vld && (wn_arr[scan_idx[k]] != wn_arr[g1_idx])) begin
          g2_vld = 1'b1;
          g2_idx = scan_idx[k];
        end
      end
    end
  end

  // Grants are suppressed during hold and during reset, even mid-operation.
  assign grant_en = !bus.hold && !Clr;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ack
      assign ack_vec[gi] = grant_en &&
                           ((g1_vld && (g1_idx == 2'(gi))) ||
                            (g2_vld && (g2_idx == 2'(gi))));
    end
  endgenerate

  assign bus.ack = ack_vec;

  // Pointer moves just past the last granted requester so it loses priority.
  assign ptr_next = (g2_vld ? g2_idx : g1_idx) + 2'd1;

  // Write port registers and pointer; addresses/data hold when not written.
  always_ff @(posedge clk) begin
    if (Clr) begin
      ptr_reg <= 2'd0;
      we1_reg <= 1'b0;
      we2_reg <= 1'b0;
      wn1_reg <= 4'd0;
      wn2_reg <= 4'd0;
      d1_reg  <= '0;
      d2_reg  <= '0;
    end else begin
      we1_reg <= g1_vld && grant_en;
      we2_reg <= g2_vld && grant_en;
      if (g1_vld && grant_en) begin
        wn1_reg <= wn_arr[g1_idx];
        d1_reg  <= d_arr[g1_idx];
        ptr_reg <= ptr_next;
      end
      if (g2_vld && grant_en) begin
        wn2_reg <= wn_arr[g2_idx];
        d2_reg  <= d_arr[g2_idx];
      end
    end
  end

  assign bus.we1 = we1_reg;
  assign bus.we2 = we2_reg;
  assign bus.wn1 = wn1_reg;
  assign bus.wn2 = wn2_reg;
  assign bus.d1  = d1_reg;
  assign bus.d2  = d2_reg;

endmodule
